// File: rtl/mm_bank_rd_seq.sv
// Skewed burst read sequencer for the banked M10K operand store.
// Lane i trails lane 0 by i cycles so data lands as a diagonal wavefront.
module mm_bank_rd_seq #(
  parameter int N_BANKS        = 16,
  parameter int W              = 8,
  parameter int DEPTH_PER_BANK = 1024,
  parameter int AW             = $clog2(DEPTH_PER_BANK),
  parameter int RD_LAT         = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [AW-1:0]                  base_addr,
  input  logic [AW:0]                    k_len,
  output logic                           busy,
  output logic                           done,
  output logic [N_BANKS-1:0]             bank_en,
  output logic [N_BANKS-1:0][AW-1:0]     bank_addr,
  input  logic [N_BANKS-1:0][W-1:0]      bank_dout,
  output logic [N_BANKS-1:0]             feed_valid,
  output logic [N_BANKS-1:0][W-1:0]      feed_data
);

  localparam int TW = $clog2(DEPTH_PER_BANK + N_BANKS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] t, t_nxt, t_last;
  logic [AW-1:0] base_q, base_nxt;
  logic [AW:0]   len_q, len_nxt;

  logic [N_BANKS-1:0]            en_nxt;
  logic [N_BANKS-1:0][AW-1:0]    addr_nxt;
  logic [N_BANKS-1:0][TW-1:0]    off;
  logic [RD_LAT-1:0][N_BANKS-1:0] vpipe;

  // Last t of the run: lane N_BANKS-1 issues its final read here.
  assign t_last = TW'(len_q) + TW'(N_BANKS) - TW'(2);

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    base_nxt  = base_q;
    len_nxt   = len_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_nxt = S_RUN;
            t_nxt     = '0;
            base_nxt  = base_addr;
            len_nxt   = k_len;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_RUN: begin
        if (t == t_last) begin
          state_nxt = S_DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (t == TW'(RD_LAT - 1)) begin
          state_nxt = S_FIN;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Enables are precomputed from next-cycle t so they leave a register.
  always_comb begin
    en_nxt   = '0;
    addr_nxt = bank_addr;
    off      = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      off[i]    = t_nxt - TW'(i);
      en_nxt[i] = (state_nxt == S_RUN)
                  && (t_nxt >= TW'(i))
                  && (off[i] < TW'(len_nxt));
      if (en_nxt[i]) begin
        addr_nxt[i] = base_nxt + off[i][AW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      t         <= '0;
      base_q    <= '0;
      len_q     <= '0;
      bank_en   <= '0;
      bank_addr <= '0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      base_q    <= base_nxt;
      len_q     <= len_nxt;
      bank_en   <= en_nxt;
      bank_addr <= addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bank_en;
      for (int k = 1; k < RD_LAT; k++) begin
        vpipe[k] <= vpipe[k-1];
      end
    end
  end

  assign feed_valid = vpipe[RD_LAT-1];

  always_comb begin
    feed_data = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (feed_valid[i]) begin
        feed_data[i] = bank_dout[i];
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule

// File: tb/tb_mm_bank_rd_seq.sv
// Bench for mm_bank_rd_seq: two instances (RD_LAT 1 and 2) share stimulus,
// each with its own transaction-level expectation queues.
module tb_mm_bank_rd_seq;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   k_len;
  logic          fin = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h",
               name, g, cyc, act, exp);
    end
  endtask

  typedef struct {
    int c;
    int v;
  } ev_t;

  logic                    busy_s [2];
  logic                    done_s [2];
  logic [N-1:0]            en_s   [2];
  logic [N-1:0]            fv_s   [2];
  logic [N-1:0][AW-1:0]    addr_s [2];
  logic [N-1:0][W-1:0]     dout_s [2];
  logic [N-1:0][W-1:0]     fd_s   [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RDL = g + 1;

    mm_bank_rd_seq #(
      .N_BANKS(N),
      .W(W),
      .DEPTH_PER_BANK(D),
      .RD_LAT(RDL)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .base_addr(base_addr),
      .k_len(k_len),
      .busy(busy_s[g]),
      .done(done_s[g]),
      .bank_en(en_s[g]),
      .bank_addr(addr_s[g]),
      .bank_dout(dout_s[g]),
      .feed_valid(fv_s[g]),
      .feed_data(fd_s[g])
    );

    // Bank memory model: mem[i][a] = 16*i + a, registered read of RDL stages.
    logic [N-1:0][W-1:0] rd [RDL];
    assign dout_s[g] = rd[RDL-1];

    always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
        if (en_s[g][i])
          rd[0][i] <= W'(16 * i + int'(addr_s[g][i]));
        else
          rd[0][i] <= W'($urandom);
      end
      for (int k = 1; k < RDL; k++) rd[k] <= rd[k-1];
    end

    ev_t enq [N][$];
    ev_t fq  [N][$];
    int  dq [$];
    int  b_lo = 0;
    int  b_hi = -1;
    bit  rst_prev = 1'b0;

    always @(posedge clk) begin
      rst_prev = !rst_n;
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          enq[i].delete();
          fq[i].delete();
        end
        dq.delete();
        b_hi = cyc;
        b_lo = cyc + 1;
      end else if (start && cyc > b_hi) begin
        int c0, k, b, dn, a;
        c0 = cyc;
        k  = int'(k_len);
        b  = int'(base_addr);
        if (k == 0) begin
          dn = c0 + 1;
        end else begin
          dn = c0 + N + k + RDL;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < k; j++) begin
              a = (b + j) % D;
              enq[i].push_back('{c0 + 1 + i + j, a});
              fq[i].push_back('{c0 + 1 + i + j + RDL, 16 * i + a});
            end
          end
        end
        dq.push_back(dn);
        b_lo = c0 + 1;
        b_hi = dn;
      end
    end

    always @(negedge clk) begin
      if (cyc > 0) begin
        for (int i = 0; i < N; i++) begin
          bit ee, fe;
          ee = enq[i].size() > 0 && enq[i][0].c == cyc;
          fe = fq[i].size() > 0 && fq[i][0].c == cyc;
          chk("bank_en", g, 32'(en_s[g][i]), 32'(ee));
          if (ee) begin
            chk("bank_addr", g, 32'(addr_s[g][i]), 32'(enq[i][0].v));
            void'(enq[i].pop_front());
          end
          chk("feed_valid", g, 32'(fv_s[g][i]), 32'(fe));
          chk("feed_data", g, 32'(fd_s[g][i]), fe ? 32'(fq[i][0].v) : 32'd0);
          if (fe) void'(fq[i].pop_front());
          if (rst_prev) chk("rst_addr", g, 32'(addr_s[g][i]), 32'd0);
        end
        begin
          bit de;
          de = dq.size() > 0 && dq[0] == cyc;
          chk("done", g, 32'(done_s[g]), 32'(de));
          if (de) void'(dq.pop_front());
        end
        chk("busy", g, 32'(busy_s[g]), 32'(cyc >= b_lo && cyc <= b_hi));
      end
    end

    always @(posedge fin) begin
      for (int i = 0; i < N; i++) begin
        chk("leftover_en", g, 32'(enq[i].size()), 32'd0);
        chk("leftover_feed", g, 32'(fq[i].size()), 32'd0);
      end
      chk("leftover_done", g, 32'(dq.size()), 32'd0);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(int b, int k);
    start     = 1'b1;
    base_addr = AW'(b);
    k_len     = (AW+1)'(k);
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    k_len     = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Baseline run, ignored start mid-run, restart right after done.
    cmd(0, 3);
    step(3);
    cmd(5, 2);
    step(4);
    cmd(0, 3);
    step(15);

    // Zero length, then address wrap.
    cmd(0, 0);
    step(4);
    cmd(6, 4);
    step(15);

    // Reset mid-run, then a fresh baseline.
    cmd(0, 3);
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    cmd(0, 3);
    step(15);

    // Full-depth burst.
    cmd(3, 8);
    step(20);

    for (int n = 0; n < 800; n++) begin
      start     = ($urandom % 3) == 0;
      base_addr = AW'($urandom % D);
      k_len     = (AW+1)'($urandom % (D + 1));
      rst_n     = ($urandom % 60) != 0;
      step(1);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step(40);

    fin = 1'b1;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
